// File: rtl/seq_bin_to_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_bin_to_bcd_if
//  Description : Handshake/data bundle between a conversion requester and the
//                iterative binary-to-BCD converter.
//                  start    requester -> converter  request a conversion
//                  bin_in   requester -> converter  unsigned binary operand
//                  busy     converter -> requester  conversion in progress
//                  done     converter -> requester  one-cycle result strobe
//                  bcd_out  converter -> requester  packed BCD, digit 0 = [3:0]
//                  overflow converter -> requester  operand exceeded 10^DIGITS-1
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_bin_to_bcd_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/seq_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : add3_if_ge5
//  Description : Double-dabble correction cell: a BCD nibble of 5 or more gets
//                3 added so that the following left shift carries correctly.
//                  nib_i  in  4  BCD digit before correction
//                  nib_o  out 4  BCD digit after correction
//  Revision    : 1.0 - initial release
// ============================================================================
module add3_if_ge5 (
    input  wire logic [3:0] nib_i,
    output logic      [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
endmodule

// ============================================================================
//  Module      : seq_bin_to_bcd
//  Description : Iterative binary-to-BCD converter, one double-dabble step per
//                clock. A conversion takes BIN_W cycles from the accepted start
//                edge to the done pulse; the result word is held until the next
//                done or reset.
//                  clk    in   system clock, rising edge
//                  reset  in   asynchronous active-high reset
//                  bus    slave side of seq_bin_to_bcd_if
//                         (start, bin_in in; busy, done, bcd_out, overflow out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_bin_to_bcd #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seq_bin_to_bcd_if.slave    bus
);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_SR_W  = c_BCD_W + BIN_W;
    localparam int c_CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [c_SR_W-1:0]    shift_q,    shift_d;
    logic [c_CNT_W-1:0]   cnt_q,      cnt_d;
    logic                 ovf_acc_q,  ovf_acc_d;
    logic [c_BCD_W-1:0]   bcd_q,      bcd_d;
    logic                 ovf_out_q,  ovf_out_d;
    logic                 done_q,     done_d;

    // Shift register after per-digit correction, before the shift.
    logic [c_SR_W-1:0]    w_corr;
    logic [c_SR_W-1:0]    w_shifted;
    logic                 w_drop;

    assign w_corr[BIN_W-1:0] = shift_q[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        add3_if_ge5 u_add3 (
            .nib_i (shift_q[BIN_W + 4*g +: 4]),
            .nib_o (w_corr [BIN_W + 4*g +: 4])
        );
    end

    // The bit leaving the top digit is a multiple of 10^DIGITS being thrown
    // away; the result is thus the operand mod 10^DIGITS and any such bit
    // flags overflow.
    assign w_shifted = {w_corr[c_SR_W-2:0], 1'b0};
    assign w_drop    = w_corr[c_SR_W-1];

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = {{c_BCD_W{1'b0}}, bus.bin_in};
                    cnt_d     = c_CNT_W'(BIN_W);
                    ovf_acc_d = 1'b0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                shift_d   = w_shifted;
                ovf_acc_d = ovf_acc_q | w_drop;
                cnt_d     = cnt_q - c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(1)) begin
                    bcd_d     = w_shifted[c_SR_W-1:BIN_W];
                    ovf_out_d = ovf_acc_q | w_drop;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy     = (state_q == CONV);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_out_q;
endmodule
`default_nettype wire
